mem_request_driver: RTL and testbench
=====================================

# mem_request_driver

Core-side initiator for the L1/L2/main-memory simulation hierarchy. Accepts one load/store at a time from a core over a valid/ready handshake and drives the hierarchy's write-enable/address/write-data port. It samples the returned read data and hit flags, then models level-dependent latency before returning a single-cycle response. Also keeps saturating per-level access counters that are snapshotted and cleared on `report`.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 8, word address width
- `L1_LAT`, 1, read latency on L1 hit, cycles; ≥1
- `L2_LAT`, 4, read latency on L2 hit, cycles; ≥1
- `MEM_LAT`, 20, latency of memory reads and of all writes, cycles; ≥1
- `CNT_WIDTH`, 16, statistics counter width

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  1  core request present
- `req_ready`  out  1  driver can accept
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_WIDTH  request address
- `req_wdata`  in  DATA_WIDTH  store data
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  DATA_WIDTH  load data; 0 for stores
- `resp_level`  out  2  0 = L1, 1 = L2, 2 = memory (stores always 2)
- `mem_write_en`  out  1  write strobe to hierarchy
- `mem_address`  out  ADDR_WIDTH  hierarchy address
- `mem_write_data`  out  DATA_WIDTH  hierarchy write data
- `mem_read_data`  in  DATA_WIDTH  hierarchy read data
- `l1_hit`, `l2_hit`  in  1 each  hierarchy hit flags
- `report`  in  1  snapshot-and-clear stats
- `stat_valid`  out  1  one-cycle pulse, snapshot updated
- `stat_l1`, `stat_l2`, `stat_mem`, `stat_wr`  out  CNT_WIDTH each  snapshotted counts

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, latch addr/wdata/write into hold registers and go to PROBE.
  - PROBE: exactly one cycle. `mem_address` and `mem_write_data` come from the hold registers. `mem_write_en` = held write flag, this cycle only.
  - At the end of PROBE, sample `l1_hit`, `l2_hit`, `mem_read_data`:
    - Level = store ? 2 : l1_hit ? 0 : l2_hit ? 1 : 2.
    - Load the wait counter with LAT(level)−1.
    - Go to WAIT if the counter value is >0, else go to RESP.
  - WAIT: decrement the counter; go to RESP when it reaches 0.
  - RESP: `resp_valid`=1 with the latched data and level; return to IDLE.
- `req_ready`=0 in every state except IDLE; no response backpressure.
- Outside PROBE: `mem_write_en`=0 and `mem_address` holds its last value.
- Statistics: one of `l1`/`l2`/`mem`/`wr` increments at the end of PROBE; loads by level, stores into `wr` only. Counters saturate at all-ones.
- On `report` high at an edge:
  - Snapshot outputs take the counter values before any same-edge increment.
  - Counters clear, then that edge's increment (if any) is applied.
  - `stat_valid` pulses in the following cycle.

## Timing
- Accept edge E0. PROBE is the cycle after E0. `resp_valid` is high in cycle LAT+1 after E0.
  - Default L1 read: response 2 cycles after accept.
  - Write: MEM_LAT+1 cycles after accept.
- Throughput: at most one request per LAT+2 cycles; the next accept is possible at the end of the cycle after RESP.
- Reset values: IDLE, `req_ready`=0 during reset then 1, all other outputs 0, counters and snapshots 0.
- Reset mid-operation:
  - The in-flight request is dropped and no `resp_valid` is issued.
  - A write already strobed in PROBE is not undone.
  - `report` coincident with `rst` is ignored.
- `l1_hit` and `l2_hit` both high: L1 wins.

## Structure
- Package `mem_driver_pkg`: state enum (IDLE/PROBE/WAIT/RESP) and level encodings (LVL_L1=0, LVL_L2=1, LVL_MEM=2).
- Sub-module `sat_counter` (width parameter; inputs inc and clr; clr-then-inc semantics), instantiated four times.

## Test plan
- Load to addr 0x10 with l1_hit=1, data 0xDEADBEEF → `resp_valid` 2 cycles after accept; rdata=0xDEADBEEF, level=0; `stat_l1` reads 1 after `report`.
- Load with l1_hit=0, l2_hit=1 → response 5 cycles after accept, level=1. Both hit flags 0 → 21 cycles, level=2.
- Store 0x12345678 to 0x20 → `mem_write_en` high exactly one cycle, with addr 0x20 and data 0x12345678; response at 21 cycles, level=2, rdata=0.
- `req_valid` held high continuously with L1 hits → `req_ready` low during PROBE/RESP; accepts spaced 3 cycles apart.
- CNT_WIDTH=2 with 5 L1 loads → `stat_l1`=3. `report` on the same edge as a PROBE end → snapshot excludes that access, counter afterwards =1.
- `rst` asserted during WAIT → no `resp_valid`, IDLE next cycle; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_driver_pkg.sv
// Shared types for the core-side memory request driver: FSM states and
// the hierarchy level encoding reported with every response.
package mem_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] LVL_L1  = 2'd0;
  localparam logic [1:0] LVL_L2  = 2'd1;
  localparam logic [1:0] LVL_MEM = 2'd2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear and an increment on the same edge yields 1.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_request_driver.sv
// Core-side initiator: one request at a time, single-cycle probe of the
// hierarchy, level-dependent latency, one-cycle response, saturating stats.
module mem_request_driver
  import mem_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int L1_LAT     = 1,
  parameter int L2_LAT     = 4,
  parameter int MEM_LAT    = 20,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_level,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  l1_hit,
  input  logic                  l2_hit,
  input  logic                  report,
  output logic                  stat_valid,
  output logic [CNT_WIDTH-1:0]  stat_l1,
  output logic [CNT_WIDTH-1:0]  stat_l2,
  output logic [CNT_WIDTH-1:0]  stat_mem,
  output logic [CNT_WIDTH-1:0]  stat_wr
);

  localparam int MAX_LAT = max3(L1_LAT, L2_LAT, MEM_LAT);
  localparam int WAIT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [WAIT_W-1:0] L1_WAIT  = WAIT_W'(L1_LAT - 1);
  localparam logic [WAIT_W-1:0] L2_WAIT  = WAIT_W'(L2_LAT - 1);
  localparam logic [WAIT_W-1:0] MEM_WAIT = WAIT_W'(MEM_LAT - 1);

  state_e                state_q;
  logic [WAIT_W-1:0]     wait_q;
  logic                  write_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [1:0]            resp_level_q;
  logic                  mem_write_en_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_write_data_q;

  logic [1:0]            level_d;
  logic [WAIT_W-1:0]     wait_d;
  logic                  probe_end;

  // Level decode of the hit flags; stores always account as memory, L1 wins ties.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    level_d = LVL_MEM;
    if (!write_q) begin
      if (l1_hit)      level_d = LVL_L1;
      else if (l2_hit) level_d = LVL_L2;
    end
    case (level_d)
      LVL_L1:  wait_d = L1_WAIT;
      LVL_L2:  wait_d = L2_WAIT;
      default: wait_d = MEM_WAIT;
    endcase
  end

  assign probe_end = (state_q == ST_PROBE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      wait_q           <= '0;
      write_q          <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      resp_level_q     <= LVL_L1;
      mem_write_en_q   <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
    end else begin
      mem_write_en_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The hierarchy port registers double as the request hold registers.
          if (req_valid) begin
            write_q          <= req_write;
            mem_address_q    <= req_addr;
            mem_write_data_q <= req_wdata;
            mem_write_en_q   <= req_write;
            state_q          <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          resp_level_q <= level_d;
          resp_rdata_q <= write_q ? '0 : mem_read_data;
          wait_q       <= wait_d;
          if (wait_d == '0) begin
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_q <= wait_q - WAIT_W'(1);
          if (wait_q == WAIT_W'(1)) begin
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == ST_IDLE) && !rst;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_level     = resp_level_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;

  logic [CNT_WIDTH-1:0] cnt_l1, cnt_l2, cnt_mem, cnt_wr;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_l1 (
    .clk(clk), .rst(rst), .clr_i(report),
    .inc_i(probe_end && (level_d == LVL_L1)), .count_o(cnt_l1)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_l2 (
    .clk(clk), .rst(rst), .clr_i(report),
    .inc_i(probe_end && (level_d == LVL_L2)), .count_o(cnt_l2)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_mem (
    .clk(clk), .rst(rst), .clr_i(report),
    .inc_i(probe_end && !write_q && (level_d == LVL_MEM)), .count_o(cnt_mem)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_wr (
    .clk(clk), .rst(rst), .clr_i(report),
    .inc_i(probe_end && write_q), .count_o(cnt_wr)
  );

  logic                 stat_valid_q;
  logic [CNT_WIDTH-1:0] stat_l1_q, stat_l2_q, stat_mem_q, stat_wr_q;

  // Snapshot captures the pre-edge counts, i.e. before any same-edge increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_valid_q <= 1'b0;
      stat_l1_q    <= '0;
      stat_l2_q    <= '0;
      stat_mem_q   <= '0;
      stat_wr_q    <= '0;
    end else begin
      stat_valid_q <= report;
      if (report) begin
        stat_l1_q  <= cnt_l1;
        stat_l2_q  <= cnt_l2;
        stat_mem_q <= cnt_mem;
        stat_wr_q  <= cnt_wr;
      end
    end
  end

  assign stat_valid = stat_valid_q;
  assign stat_l1    = stat_l1_q;
  assign stat_l2    = stat_l2_q;
  assign stat_mem   = stat_mem_q;
  assign stat_wr    = stat_wr_q;

endmodule

// File: tb/tb_mem_request_driver.sv
// Directed bench for mem_request_driver: transaction-level timing model plus
// hand-computed expectations for latency, data, level and statistics.
module tb_mem_request_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_level;
  logic        mem_write_en;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        l1_hit = 1'b0;
  logic        l2_hit = 1'b0;
  logic        report = 1'b0;
  logic        stat_valid;
  logic [1:0]  stat_l1, stat_l2, stat_mem, stat_wr;

  mem_request_driver #(.CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_level(resp_level),
    .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .l1_hit(l1_hit), .l2_hit(l2_hit), .report(report),
    .stat_valid(stat_valid), .stat_l1(stat_l1), .stat_l2(stat_l2),
    .stat_mem(stat_mem), .stat_wr(stat_wr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction model: cycle numbers of each phase, derived from the latency rules.
  int          cyc = 0;
  int          free_from = 0;
  int          probe_cyc = -10;
  int          resp_cyc = -10;
  bit          m_write = 1'b0;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] m_rdata = '0;
  int          m_level = 0;
  int          cnt[4] = '{0, 0, 0, 0};
  int          snap[4] = '{0, 0, 0, 0};
  bit          sv_exp = 1'b0;

  function automatic int lat_of(input int lvl);
    return (lvl == 0) ? 1 : (lvl == 1) ? 4 : 20;
  endfunction

  always @(posedge clk) begin
    int idx;
    cyc++;
    if (rst) begin
      free_from = cyc;
      probe_cyc = -10;
      resp_cyc  = -10;
      m_write   = 1'b0;
      last_addr = '0;
      last_wdata = '0;
      sv_exp    = 1'b0;
      for (int i = 0; i < 4; i++) begin cnt[i] = 0; snap[i] = 0; end
    end else begin
      idx = -1;
      if (probe_cyc == cyc - 1) begin
        m_level   = m_write ? 2 : l1_hit ? 0 : l2_hit ? 1 : 2;
        m_rdata   = m_write ? 32'h0 : mem_read_data;
        resp_cyc  = probe_cyc + lat_of(m_level);
        free_from = resp_cyc + 1;
        idx       = m_write ? 3 : m_level;
      end
      sv_exp = report;
      if (report) begin
        for (int i = 0; i < 4; i++) begin snap[i] = cnt[i]; cnt[i] = 0; end
      end
      if (idx >= 0 && cnt[idx] < 3) cnt[idx]++;
      if (req_valid && (cyc - 1) >= free_from) begin
        probe_cyc  = cyc;
        free_from  = cyc + 1000000;
        m_write    = req_write;
        last_addr  = req_addr;
        last_wdata = req_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, !rst && cyc >= free_from);
      check("resp_valid", resp_valid, cyc == resp_cyc);
      if (cyc == resp_cyc) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_level", resp_level, m_level);
      end
      check("mem_write_en", mem_write_en, (cyc == probe_cyc) && m_write);
      check("mem_address", mem_address, last_addr);
      check("mem_write_data", mem_write_data, last_wdata);
      check("stat_valid", stat_valid, sv_exp);
      check("stat_l1", stat_l1, snap[0]);
      check("stat_l2", stat_l2, snap[1]);
      check("stat_mem", stat_mem, snap[2]);
      check("stat_wr", stat_wr, snap[3]);
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    check("wait_ready_bound", k < 100, 1'b1);
  endtask

  // Issue one request and measure the cycle of resp_valid counted from the accept edge.
  task automatic do_req(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic l1, input logic l2,
                        input logic [31:0] rd, input logic rpt, input int exp_n,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_level);
    int   n;
    logic rv;
    wait_ready();
    #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    l1_hit = l1; l2_hit = l2; mem_read_data = rd;
    @(negedge clk);
    n = 1;
    check({tag, "_probe_we"}, mem_write_en, wr);
    check({tag, "_probe_addr"}, mem_address, addr);
    check({tag, "_probe_wdata"}, mem_write_data, wdata);
    #1;
    req_valid = 1'b0;
    report = rpt;
    rv = 1'b0;
    while (!rv && n < 60) begin
      @(negedge clk);
      n++;
      rv = resp_valid;
      #1 report = 1'b0;
    end
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_level"}, resp_level, exp_level);
  endtask

  task automatic do_report(input logic [1:0] e_l1, input logic [1:0] e_l2,
                           input logic [1:0] e_mem, input logic [1:0] e_wr);
    @(negedge clk);
    #1 report = 1'b1;
    @(negedge clk);
    check("rpt_valid", stat_valid, 1'b1);
    check("rpt_l1", stat_l1, e_l1);
    check("rpt_l2", stat_l2, e_l2);
    check("rpt_mem", stat_mem, e_mem);
    check("rpt_wr", stat_wr, e_wr);
    #1 report = 1'b0;
    @(negedge clk);
    check("rpt_valid_pulse", stat_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int lows;
    @(posedge clk);
    chk_en = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mem_we", mem_write_en, 1'b0);
    check("rst_mem_addr", mem_address, 8'h00);
    check("rst_stat_l1", stat_l1, 2'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    do_req("l1_load", 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF, 2'd0);
    do_report(2'd1, 2'd0, 2'd0, 2'd0);

    do_req("l2_load", 1'b0, 8'h11, 32'h1, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 5, 32'hCAFE0001, 2'd1);
    do_req("mem_load", 1'b0, 8'h12, 32'h2, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 21, 32'h0BADF00D, 2'd2);
    do_req("store", 1'b1, 8'h20, 32'h12345678, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 21, 32'h0, 2'd2);

    // Back-to-back L1 loads with req_valid held high: accepts every 3 cycles.
    wait_ready();
    #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30; req_wdata = 32'h3;
    l1_hit = 1'b1; l2_hit = 1'b0; mem_read_data = 32'h11110000;
    pulses = 0;
    lows = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) pulses++;
      if (!req_ready) lows++;
    end
    #1 req_valid = 1'b0;
    check("b2b_responses", pulses, 4);
    check("b2b_ready_low_cycles", lows, 8);

    do_req("l1_fifth", 1'b0, 8'h31, 32'h4, 1'b1, 1'b0, 32'h22223333, 1'b0, 2, 32'h22223333, 2'd0);
    do_report(2'd3, 2'd1, 2'd1, 2'd1);

    do_req("l2_pre", 1'b0, 8'h32, 32'h5, 1'b0, 1'b1, 32'h44445555, 1'b0, 5, 32'h44445555, 2'd1);
    do_req("l1_rpt", 1'b0, 8'h33, 32'h6, 1'b1, 1'b0, 32'h66667777, 1'b1, 2, 32'h66667777, 2'd0);
    check("coinc_snap_l1", stat_l1, 2'd0);
    check("coinc_snap_l2", stat_l2, 2'd1);
    do_report(2'd1, 2'd0, 2'd0, 2'd0);

    // Reset while waiting on a memory read, with a coincident report.
    wait_ready();
    #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40; req_wdata = 32'h7;
    l1_hit = 1'b0; l2_hit = 1'b0; mem_read_data = 32'h55AA55AA;
    @(negedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    report = 1'b1;
    @(negedge clk);
    check("midrst_ready", req_ready, 1'b0);
    check("midrst_stat_valid", stat_valid, 1'b0);
    #1;
    rst = 1'b0;
    report = 1'b0;
    @(negedge clk);
    check("midrst_idle_after", req_ready, 1'b1);
    check("midrst_no_stat_valid", stat_valid, 1'b0);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("midrst_no_resp", pulses, 0);

    do_req("both_hits", 1'b0, 8'h50, 32'h8, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 2, 32'hA5A5A5A5, 2'd0);
    do_report(2'd1, 2'd0, 2'd0, 2'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
